// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one add/sub-and-shift per cycle
module booth_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH:0]       a, m_reg, sum;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH+1:0]   shifted;
  logic [WIDTH:0]       a_n;
  logic [WIDTH-1:0]     q_n;
  logic                 q1_n, accept, last;
  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  always_comb begin
    sum     = ({q[0], q_1} == 2'b10) ? a - m_reg :
              ({q[0], q_1} == 2'b01) ? a + m_reg : a;
    shifted = {sum[WIDTH], sum, q};
    a_n     = shifted[2*WIDTH+1:WIDTH+1];
    q_n     = shifted[WIDTH:1];
    q1_n    = shifted[0];
    state_d = accept ? RUN :
              last ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a       <= '0;
      q       <= multiplier;
      q_1     <= 1'b0;
      m_reg   <= {multiplicand[WIDTH-1], multiplicand};
      cnt     <= '0;
    end else if (state == RUN) begin
      a       <= a_n;
      q       <= q_n;
      q_1     <= q1_n;
      cnt     <= cnt + CW'(1);
      if (last) product <= {a_n[WIDTH-1:0], q_n};
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and exhaustive checks of the 4-bit Booth multiplier
module tb_booth_mult_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] multiplicand = '0;
  logic [3:0] multiplier = '0;
  logic       busy, done;
  logic [7:0] product;
  int vectors = 0;
  int miscompares = 0;

  booth_mult_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(multiplicand),
    .multiplier(multiplier), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a multiply in the current IDLE cycle and waits for done (bounded).
  task automatic mult(input string tag, input logic [3:0] m, input logic [3:0] q,
                      input logic [7:0] exp, input bit full);
    int n, nb;
    bit ovl;
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(negedge clk);
    start = 1'b0; multiplicand = ~m; multiplier = ~q;
    n = 0; nb = 0; ovl = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (busy && done) ovl = 1;
    chk({tag, "_prod"}, 32'(product), 32'(exp));
    if (full) begin
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_busy"}, nb, 4);
      chk({tag, "_ovl"}, 32'(ovl), 0);
    end
  endtask

  initial begin
    int n, ndone;
    logic [7:0] e;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prod", 32'(product), 0);
    @(negedge clk); rst = 1'b0;

    mult("t1_3x5",  4'b0011, 4'b0101, 8'h0F, 1);
    mult("t2_m3x5", 4'b1101, 4'b0101, 8'hF1, 1);
    mult("t3_m8m8", 4'b1000, 4'b1000, 8'h40, 1);
    mult("t3_7m8",  4'b0111, 4'b1000, 8'hC8, 1);
    mult("t3_0xq",  4'b0000, 4'b1011, 8'h00, 1);

    // start pulse during RUN must be ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd2; multiplier = 4'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0; ndone = 0;
    while (n < 12) begin
      if (done) ndone++;
      @(negedge clk);
      n++;
    end
    chk("t4_ndone", ndone, 1);
    chk("t4_prod", 32'(product), 32'h0F);
    chk("t4_idle", 32'(busy), 0);

    // reset mid-run aborts and clears product
    @(negedge clk);
    start = 1'b1; multiplicand = 4'b1101; multiplier = 4'b0101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_prod", 32'(product), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("t5_nodone", ndone, 0);
    chk("t5_prod_hold", 32'(product), 0);
    mult("t5_2x3", 4'd2, 4'd3, 8'h06, 1);

    for (int mi = -8; mi < 8; mi++)
      for (int qi = -8; qi < 8; qi++) begin
        int p;
        p = mi * qi;
        e = p[7:0];
        mult("ex", 4'(mi), 4'(qi), e, 0);
      end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
